// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment digit scanner with per-slot dead-time blanking and
// frame-synchronous copy of host-written codes into the display registers.
module display_scanner #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned AW     = 2,
    parameter int unsigned DIV    = 1000,
    parameter int unsigned BLANK  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [4:0]        wr_data,
    output logic [4:0]        code,
    output logic [DIGITS-1:0] dig,
    output logic              frame
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4:0]        stage_q  [DIGITS];
    logic [4:0]        shadow_q [DIGITS];

    logic              slot_end;
    logic              frame_end;
    logic              show;
    logic [DIGITS-1:0] dig_d;
    logic [4:0]        code_d;

    assign slot_end  = (cnt_q == CW'(DIV - 1));
    assign frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
    assign show      = (cnt_q >= CW'(BLANK));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Code follows idx in both phases so the decoder settles before dig turns on.
    always_comb begin
        dig_d  = '0;
        code_d = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                dig_d[i] = show && en;
                code_d   = shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            dig   <= '0;
            code  <= '0;
            frame <= 1'b0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                stage_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            dig   <= dig_d;
            code  <= code_d;
            frame <= frame_end;
            // Shadow takes the pre-edge stage value; a same-edge write waits a frame.
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    stage_q[i] <= wr_data;
                end
                if (frame_end) begin
                    shadow_q[i] <= stage_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: scan timing, frame-synchronous update,
// out-of-range and overwrite writes, enable gating and mid-frame reset.
module tb_display_scanner;

    localparam int unsigned Div = 16;
    localparam int unsigned Blk = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Four-digit instance
    logic       rst = 1'b1, en = 1'b1, wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [4:0] code;
    logic [3:0] dig;
    logic       frame;

    // Three-digit instance
    logic       rst3 = 1'b1, wr_en3 = 1'b0;
    logic [1:0] wr_addr3 = '0;
    logic [4:0] wr_data3 = '0;
    logic [4:0] code3;
    logic [2:0] dig3;
    logic       frame3;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    display_scanner #(.DIGITS(4), .AW(2), .DIV(Div), .BLANK(Blk)) u_dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .code(code), .dig(dig), .frame(frame)
    );

    display_scanner #(.DIGITS(3), .AW(2), .DIV(Div), .BLANK(Blk)) u_dut3 (
        .clk(clk), .rst(rst3), .en(1'b1), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .code(code3), .dig(dig3), .frame(frame3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected dig in cycle n (n>=1) from the slot timing formula.
    function automatic int unsigned exp_dig(input int n, input int nd, input bit e);
        int c;
        int i;
        c = (n - 1) % int'(Div);
        i = ((n - 1) / int'(Div)) % nd;
        return (e && c >= int'(Blk)) ? (32'd1 << i) : 32'd0;
    endfunction

    // Displayed codes per frame for the four-digit run.
    function automatic logic [4:0] exp_code4(input int f, input int i);
        if (f == 0) return 5'h00;
        case (i)
            0:       return 5'h13;
            1:       return (f >= 2) ? 5'h07 : 5'h00;
            3:       return 5'h0A;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [4:0] exp_code3(input int f, input int i);
        return (f >= 1 && i == 2) ? 5'h09 : 5'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset4(input int cycles);
        rst   = 1'b1;
        en    = 1'b1;
        wr_en = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            step();
            check("rst_dig",   32'(dig),   32'd0);
            check("rst_code",  32'(code),  32'd0);
            check("rst_frame", 32'(frame), 32'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        bit e;
        int f;
        int i;

        // Scan, frame update, copy-edge write, enable gating
        reset4(3);
        for (int n = 1; n <= 170; n++) begin
            wr_en = 1'b0;
            case (n)
                10: begin wr_en = 1'b1; wr_addr = 2'd0; wr_data = 5'h13; end
                11: begin wr_en = 1'b1; wr_addr = 2'd3; wr_data = 5'h0A; end
                64: begin wr_en = 1'b1; wr_addr = 2'd1; wr_data = 5'h07; end
                default: ;
            endcase
            e  = !(n >= 21 && n <= 41);
            en = e;
            step();
            f = (n - 1) / int'(4 * Div);
            i = ((n - 1) / int'(Div)) % 4;
            check($sformatf("scan_dig@%0d", n),   32'(dig),   exp_dig(n, 4, e));
            check($sformatf("scan_frame@%0d", n), 32'(frame), 32'((n % int'(4 * Div)) == 0));
            check($sformatf("scan_code@%0d", n),  32'(code),  32'(exp_code4(f, i)));
        end
        wr_en = 1'b0;
        en    = 1'b1;

        // Reset mid-frame discards staged codes
        reset4(1);
        for (int n = 1; n <= 49; n++) begin
            wr_en = 1'b0;
            case (n)
                5: begin wr_en = 1'b1; wr_addr = 2'd2; wr_data = 5'h1E; end
                6: begin wr_en = 1'b1; wr_addr = 2'd0; wr_data = 5'h11; end
                default: ;
            endcase
            step();
        end
        wr_en = 1'b0;
        reset4(1);
        for (int n = 1; n <= 140; n++) begin
            step();
            check($sformatf("rerun_dig@%0d", n),   32'(dig),   exp_dig(n, 4, 1'b1));
            check($sformatf("rerun_frame@%0d", n), 32'(frame), 32'((n % int'(4 * Div)) == 0));
            check($sformatf("rerun_code@%0d", n),  32'(code),  32'd0);
        end

        // Three digits: out-of-range write ignored, last write to an address wins
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            wr_en3 = 1'b0;
            case (n)
                5: begin wr_en3 = 1'b1; wr_addr3 = 2'd3; wr_data3 = 5'h1F; end
                6: begin wr_en3 = 1'b1; wr_addr3 = 2'd2; wr_data3 = 5'h04; end
                7: begin wr_en3 = 1'b1; wr_addr3 = 2'd2; wr_data3 = 5'h09; end
                default: ;
            endcase
            step();
            f = (n - 1) / int'(3 * Div);
            i = ((n - 1) / int'(Div)) % 3;
            check($sformatf("d3_dig@%0d", n),   32'(dig3),   exp_dig(n, 3, 1'b1));
            check($sformatf("d3_frame@%0d", n), 32'(frame3), 32'((n % int'(3 * Div)) == 0));
            check($sformatf("d3_code@%0d", n),  32'(code3),  32'(exp_code3(f, i)));
        end
        wr_en3 = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
